// File: rtl/pagerank_engine_if.sv
// Handshake and data bundle between a PageRank requester (master) and the engine (slave).
interface pagerank_engine_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int ITW   = 6
);
  logic                 start;
  logic [N*N-1:0]       adjacency;
  logic [N*WIDTH-1:0]   weights;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic [ITW-1:0]       iter_count;
  logic [N*WIDTH-1:0]   rank;

  modport master (
    output start, adjacency, weights,
    input  busy, done, converged, iter_count, rank
  );

  modport slave (
    input  start, adjacency, weights,
    output busy, done, converged, iter_count, rank
  );
endinterface

// File: rtl/pagerank_engine.sv
// Fixed-point PageRank engine: one multiply-accumulate per cycle, Jacobi iteration
// until every node moves by at most EPS or MAX_ITER iterations have been run.
module pagerank_engine #(
  parameter int               N        = 4,
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] D_FRAC   = 16'h2666,
  parameter int               MAX_ITER = 32,
  parameter logic [WIDTH-1:0] EPS      = 16'h0010
) (
  input logic              clk,
  input logic              reset,
  pagerank_engine_if.slave bus
);

  localparam int ITW  = $clog2(MAX_ITER + 1);
  localparam int IDXW = $clog2(N);
  localparam int AW   = $clog2(N * N);
  localparam int ACCW = WIDTH + $clog2(N) + 1;
  localparam int PW   = 3 * WIDTH + 1;

  localparam logic [WIDTH:0]   ONE       = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   DB        = ONE - {1'b0, D_FRAC};
  localparam logic [WIDTH-1:0] DN        = WIDTH'(D_FRAC / WIDTH'(N));
  localparam logic [WIDTH-1:0] INIT_RANK = WIDTH'(ONE / (WIDTH + 1)'(N));
  localparam logic [WIDTH-1:0] MAXV      = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACCUM,
    COMMIT,
    DONE
  } state_t;

  state_t            state;
  logic [N*N-1:0]    adj_q;
  logic [WIDTH-1:0]  w_q    [N];
  logic [WIDTH-1:0]  rank_q [N];
  logic [WIDTH-1:0]  next_q [N];
  logic [ACCW-1:0]   acc;
  logic [IDXW-1:0]   p_idx;
  logic [IDXW-1:0]   k_idx;
  logic [ITW-1:0]    iter_q;
  logic              conv_q;
  logic              busy_q;
  logic              done_q;

  logic [AW-1:0]     adj_sel;
  logic [ACCW-1:0]   term;
  logic [ACCW-1:0]   acc_sum;
  logic [ACCW:0]     row_total;
  logic [WIDTH-1:0]  row_value;
  logic [WIDTH-1:0]  diff;
  logic              all_close;
  logic              last_iter;

  // Datapath for the current (p,k) pair; ranks read here are always last iteration's
  always_comb begin
    adj_sel   = AW'(int'(p_idx) * N + int'(k_idx));
    term      = ACCW'((PW'(DB) * PW'(w_q[k_idx]) * PW'(rank_q[k_idx])) >> (2 * WIDTH));
    acc_sum   = adj_q[adj_sel] ? acc + term : acc;
    row_total = (ACCW + 1)'(DN) + (ACCW + 1)'(acc_sum);
    row_value = (row_total > (ACCW + 1)'(MAXV)) ? MAXV : WIDTH'(row_total);
    last_iter = (int'(iter_q) + 1 == MAX_ITER);
    diff      = '0;
    all_close = 1'b1;
    for (int i = 0; i < N; i++) begin
      diff = (next_q[i] >= rank_q[i]) ? next_q[i] - rank_q[i] : rank_q[i] - next_q[i];
      if (diff > EPS) begin
        all_close = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      adj_q  <= '0;
      acc    <= '0;
      p_idx  <= '0;
      k_idx  <= '0;
      iter_q <= '0;
      conv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        w_q[i]    <= '0;
        rank_q[i] <= '0;
        next_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          adj_q  <= bus.adjacency;
          acc    <= '0;
          p_idx  <= '0;
          k_idx  <= '0;
          iter_q <= '0;
          conv_q <= 1'b0;
          for (int i = 0; i < N; i++) begin
            w_q[i]    <= bus.weights[i*WIDTH +: WIDTH];
            rank_q[i] <= INIT_RANK;
          end
          state <= ACCUM;
        end
        ACCUM: begin
          if (k_idx == IDXW'(N - 1)) begin
            next_q[p_idx] <= row_value;
            acc           <= '0;
            k_idx         <= '0;
            if (p_idx == IDXW'(N - 1)) begin
              p_idx <= '0;
              state <= COMMIT;
            end else begin
              p_idx <= p_idx + 1'b1;
            end
          end else begin
            acc   <= acc_sum;
            k_idx <= k_idx + 1'b1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < N; i++) begin
            rank_q[i] <= next_q[i];
          end
          iter_q <= iter_q + 1'b1;
          conv_q <= all_close;
          if (all_close || last_iter) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= ACCUM;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.converged  = conv_q;
  assign bus.iter_count = iter_q;

  for (genvar g = 0; g < N; g++) begin : g_rank
    assign bus.rank[g*WIDTH +: WIDTH] = rank_q[g];
  end

endmodule

// File: tb/tb_pagerank_engine.sv
// Scoreboard bench for pagerank_engine: default instance plus a MAX_ITER=1 instance.
module tb_pagerank_engine;

  typedef struct {
    logic [63:0] rank;
    logic        conv;
    int          iter;
    int          latency;
  } exp_t;

  logic clk;
  logic reset;

  logic        start_drv;
  logic        use_one;
  logic [15:0] adj_drv;
  logic [63:0] w_drv;

  logic [63:0] rank_s;
  logic [31:0] iter_s;
  logic        busy_s;
  logic        done_s;
  logic        conv_s;

  int checks;
  int errors;
  exp_t sb[$];

  pagerank_engine_if #(.N(4), .WIDTH(16), .ITW(6)) bus ();
  pagerank_engine_if #(.N(4), .WIDTH(16), .ITW(1)) bus1 ();

  pagerank_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  pagerank_engine #(.MAX_ITER(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  assign bus.start      = start_drv & ~use_one;
  assign bus1.start     = start_drv & use_one;
  assign bus.adjacency  = adj_drv;
  assign bus1.adjacency = adj_drv;
  assign bus.weights    = w_drv;
  assign bus1.weights   = w_drv;

  assign rank_s = use_one ? bus1.rank : bus.rank;
  assign iter_s = use_one ? 32'(bus1.iter_count) : 32'(bus.iter_count);
  assign busy_s = use_one ? bus1.busy : bus.busy;
  assign done_s = use_one ? bus1.done : bus.done;
  assign conv_s = use_one ? bus1.converged : bus.converged;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Independent whole-iteration reference for N=4, WIDTH=16, default D_FRAC and EPS
  function automatic exp_t modelRun(input logic [15:0] adj, input logic [63:0] w, input int max_iter);
    exp_t   e;
    longint r  [4];
    longint nx [4];
    longint acc;
    longint d;
    int     it;
    bit     conv;
    for (int i = 0; i < 4; i++) r[i] = 16384;
    it   = 0;
    conv = 0;
    while (!conv && it < max_iter) begin
      for (int p = 0; p < 4; p++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) begin
          if (adj[p*4+k]) acc += (longint'(16'hD99A) * longint'(w[k*16 +: 16]) * r[k]) >>> 32;
        end
        nx[p] = 2457 + acc;
        if (nx[p] > 65535) nx[p] = 65535;
      end
      conv = 1;
      for (int p = 0; p < 4; p++) begin
        d = nx[p] - r[p];
        if (d < 0) d = -d;
        if (d > 16) conv = 0;
        r[p] = nx[p];
      end
      it++;
    end
    for (int p = 0; p < 4; p++) e.rank[p*16 +: 16] = 16'(r[p]);
    e.conv    = conv;
    e.iter    = it;
    e.latency = 1 + it * 17;
    return e;
  endfunction

  task automatic scoreRun(input int edges);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput("latency", 64'(edges), 64'(e.latency));
    checkOutput("converged", 64'(conv_s), 64'(e.conv));
    checkOutput("iter_count", 64'(iter_s), 64'(e.iter));
    checkOutput("rank", rank_s, e.rank);
    @(posedge clk);
    #1;
    checkOutput("done_pulse", 64'(done_s), 64'd0);
    checkOutput("busy_idle", 64'(busy_s), 64'd0);
    checkOutput("rank_held", rank_s, e.rank);
  endtask

  task automatic applyStimulus(input logic [15:0] adj, input logic [63:0] w, input bit one,
                               input bit perturb, input exp_t e);
    int edges;
    sb.push_back(e);
    use_one = one;
    adj_drv = adj;
    w_drv   = w;
    @(negedge clk);
    start_drv = 1'b1;
    @(posedge clk);
    #1;
    start_drv = 1'b0;
    checkOutput("busy_start", 64'(busy_s), 64'd1);
    edges = 0;
    while (edges < 2000) begin
      @(posedge clk);
      edges++;
      #1;
      if (perturb) begin
        if (edges == 1) begin
          adj_drv = ~adj;
          w_drv   = {$urandom, $urandom};
        end
        start_drv = (edges >= 2 && edges <= 5);
      end
      if (done_s) break;
    end
    scoreRun(edges);
  endtask

  initial begin
    exp_t e;
    int   n;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    start_drv = 1'b0;
    use_one   = 1'b0;
    adj_drv   = '0;
    w_drv     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_conv", 64'(bus.converged), 64'd0);
    checkOutput("rst_iter", 64'(bus.iter_count), 64'd0);
    checkOutput("rst_rank", bus.rank, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Isolated nodes: all ranks fall to the teleport floor, converged on the second pass
    e = '{rank: {4{16'h0999}}, conv: 1'b1, iter: 2, latency: 35};
    applyStimulus(16'h0000, {4{16'h4000}}, 1'b0, 1'b0, e);

    e = '{rank: {4{16'h3FFD}}, conv: 1'b1, iter: 1, latency: 18};
    applyStimulus(16'hFFFF, {4{16'h4000}}, 1'b0, 1'b0, e);

    e = '{rank: {4{16'hFFFF}}, conv: 1'b1, iter: 3, latency: 52};
    applyStimulus(16'hFFFF, {4{16'hFFFF}}, 1'b0, 1'b0, e);

    e = '{rank: {4{16'h0999}}, conv: 1'b0, iter: 1, latency: 18};
    applyStimulus(16'h0000, {4{16'h4000}}, 1'b1, 1'b0, e);

    // Abort a run during its second iteration with an asynchronous reset
    use_one = 1'b0;
    adj_drv = 16'h0000;
    @(negedge clk);
    start_drv = 1'b1;
    @(posedge clk);
    #1;
    start_drv = 1'b0;
    n = 0;
    while (n < 25) begin
      @(posedge clk);
      n++;
    end
    #2;
    checkOutput("pre_rst_iter", 64'(bus.iter_count), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("mid_rst_rank", bus.rank, 64'd0);
    checkOutput("mid_rst_iter", 64'(bus.iter_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    e = '{rank: {4{16'h0999}}, conv: 1'b1, iter: 2, latency: 35};
    applyStimulus(16'h0000, {4{16'h4000}}, 1'b0, 1'b0, e);

    e = '{rank: {4{16'h3FFD}}, conv: 1'b1, iter: 1, latency: 18};
    applyStimulus(16'hFFFF, {4{16'h4000}}, 1'b0, 1'b1, e);

    for (int t = 0; t < 3; t++) begin
      adj_drv = 16'($urandom);
      w_drv   = {$urandom, $urandom};
      e = modelRun(adj_drv, w_drv, 32);
      applyStimulus(adj_drv, w_drv, 1'b0, 1'b0, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pagerank_engine.md
PAGERANK_ENGINE -- requirements
Module: pagerank_engine

Interface
REQ-001 SHALL have parameter N, default 4, meaning node count (2..16).
REQ-002 SHALL have parameter WIDTH, default 16, meaning unsigned fraction width of every rank and weight (value = raw/2^WIDTH).
REQ-003 SHALL have parameter D_FRAC, default 16'h2666, meaning teleport factor d as a WIDTH-bit fraction (0.15).
REQ-004 SHALL have parameter MAX_ITER, default 32, meaning iteration cap (>=1).
REQ-005 SHALL have parameter EPS, default 16'h0010, meaning convergence threshold on per-node |delta|.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 start  input  1  request a run; sampled only in IDLE.
REQ-009 adjacency  input  N*N  bit p*N+k set means node k links to node p.
REQ-010 weights  input  N*WIDTH  slice k = weight of node k (normally 1/outdegree).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at run end.
REQ-013 converged  output  1  result flag, valid from done until the next accepted start.
REQ-014 iter_count  output  $clog2(MAX_ITER+1)  iterations completed in the current/last run.
REQ-015 rank  output  N*WIDTH  slice p = registered rank of node p.

Function
REQ-016 SHALL implement states IDLE, LOAD, ACCUM, COMMIT, DONE.
REQ-017 IDLE: start=1 -> LOAD; start in any other state SHALL be ignored.
REQ-018 LOAD (1 cycle): latch adjacency and weights into internal registers, set every rank to floor(2^WIDTH/N), clear iter_count, clear converged, row p=0, column k=0, accumulator=0.
REQ-019 Input changes after LOAD SHALL NOT affect the run.
REQ-020 ACCUM: one (p,k) pair per cycle, k inner, p outer; N*N cycles per iteration.
REQ-021 Per cycle, if latched adj bit p*N+k set: acc += (DB*w[k]*rank[k]) >> 2*WIDTH, DB = 2^WIDTH - D_FRAC, full 3*WIDTH-bit product, truncation.
REQ-022 Accumulator SHALL be WIDTH+$clog2(N)+1 bits and SHALL NOT wrap.
REQ-023 At k=N-1: next[p] = min(DN + acc, 2^WIDTH-1), DN = floor(D_FRAC/N); acc cleared; p advances; after p=N-1 -> COMMIT.
REQ-024 A row with no set bits SHALL yield next[p]=DN.
REQ-025 Reads of rank[] during ACCUM SHALL use previous-iteration values only (Jacobi update).
REQ-026 COMMIT (1 cycle): rank <= next; iter_count += 1; converged <= (|next[p]-rank[p]| <= EPS for all p).
REQ-027 COMMIT exit: converged or iter_count+1 == MAX_ITER -> DONE, else -> ACCUM with p=k=0.
REQ-028 DONE (1 cycle): done=1, then IDLE; rank, iter_count, converged held in IDLE.
REQ-029 Latency: done SHALL rise exactly 1 + I*(N*N+1) rising edges after the edge sampling start, I = iterations run.

Reset
REQ-030 reset SHALL force IDLE, rank=0, iter_count=0, busy=0, done=0, converged=0, acc=0, p=k=0, immediately and in any state.
REQ-031 After reset deasserts, the first start SHALL run normally with no residue from an aborted run.

Verification (N=4, WIDTH=16, defaults unless noted)
REQ-032 adjacency=0, start -> iteration 1 ranks 0x4000->0x0999 (not converged), iteration 2 delta 0; done 35 edges after start, converged=1, iter_count=2, all ranks 0x0999.
REQ-033 adjacency all ones, weights all 0x4000 -> each term 0x0D99, ranks 0x3FFD, delta 3; done 18 edges after start, converged=1, iter_count=1.
REQ-034 adjacency all ones, weights all 0xFFFF -> iteration 1 ranks 0xE331, iteration 2 saturate to 0xFFFF, iteration 3 delta 0; converged=1, iter_count=3.
REQ-035 MAX_ITER=1, adjacency=0 -> done after 18 edges, converged=0, iter_count=1, ranks 0x0999.
REQ-036 reset pulsed mid-ACCUM -> same cycle busy=0, rank=0, iter_count=0; next start reproduces REQ-032 exactly.
REQ-037 start re-pulsed while busy and adjacency/weights changed after LOAD -> no effect; results and timing identical to the unperturbed run.
